// File: rtl/costas_acq_ctrl_if.sv
// Signal bundle between the BPSK Costas loop (master) and its acquisition controller (slave).
interface costas_acq_ctrl_if;
  logic signed [25:0] di;
  logic signed [25:0] dq;
  logic        [29:0] carrier;
  logic               loop_clr;
  logic               lock;
  logic        [2:0]  acq_state;
  logic signed [4:0]  sweep_pos;

  modport master (output di, dq, input carrier, loop_clr, lock, acq_state, sweep_pos);
  modport slave  (input di, dq, output carrier, loop_clr, lock, acq_state, sweep_pos);
endinterface

// File: rtl/costas_acq_ctrl.sv
// Costas loop acquisition/lock controller: zig-zag carrier sweep, loop clear, I/Q window energy lock detect.
// Optional feature macro: ACQ_SWEEP_EN (undefined -> carrier pinned at CENTER, sweep_pos stays 0).
module costas_acq_ctrl #(
  parameter logic [29:0] CENTER     = 30'd53687091,
  parameter logic [29:0] STEP       = 30'd268435,
  parameter int          NSTEP      = 8,
  parameter int          WIN_LOG2   = 10,
  parameter int          SETTLE_CYC = 2048,
  parameter int          DWELL_WIN  = 4,
  parameter int          LOCK_CNT   = 3,
  parameter int          UNLOCK_CNT = 8,
  parameter logic [31:0] MIN_E      = 32'd1 << 20
) (
  input logic              clk,
  input logic              reset_n,
  costas_acq_ctrl_if.slave bus
);

  localparam int ACC_W = 26 + WIN_LOG2;
  localparam int CMP_W = (ACC_W + 1 > 32) ? ACC_W + 1 : 32;
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int CNT_W = 8;

  localparam logic [2:0] ST_CLEAR   = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_MEASURE = 3'd2;
  localparam logic [2:0] ST_TRACK   = 3'd3;

  localparam logic [SET_W-1:0]    SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [SET_W-1:0]    SET_ONE     = SET_W'(1);
  localparam logic [WIN_LOG2-1:0] WIN_LAST    = '1;
  localparam logic [WIN_LOG2-1:0] WIN_ONE     = WIN_LOG2'(1);
  localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]    LOCK_LAST   = CNT_W'(LOCK_CNT - 1);
  localparam logic [CNT_W-1:0]    DWELL_LAST  = CNT_W'(DWELL_WIN - 1);
  localparam logic [CNT_W-1:0]    UNLOCK_LAST = CNT_W'(UNLOCK_CNT - 1);
  localparam logic signed [4:0]   POS_MIN     = 5'(-NSTEP);

`ifdef ACQ_SWEEP_EN
  localparam bit SWEEP_EN = 1'b1;
`else
  localparam bit SWEEP_EN = 1'b0;
`endif

  logic [2:0]          state_reg,   state_next;
  logic [SET_W-1:0]    settle_reg,  settle_next;
  logic [WIN_LOG2-1:0] win_pos_reg, win_pos_next;
  logic [ACC_W-1:0]    acc_i_reg,   acc_i_next;
  logic [ACC_W-1:0]    acc_q_reg,   acc_q_next;
  logic [CNT_W-1:0]    good_reg,    good_next;
  logic [CNT_W-1:0]    bad_reg,     bad_next;
  logic [CNT_W-1:0]    dwell_reg,   dwell_next;
  logic                lock_reg,    lock_next;
  logic signed [4:0]   sweep_reg,   sweep_next;
  logic [29:0]         carrier_reg, carrier_next;

  logic [25:0] samp [2];
  logic [24:0] mag  [2];
  assign samp[0] = bus.di;
  assign samp[1] = bus.dq;

  // |x| with the single unrepresentable value -2^25 clamped to 2^25-1.
  for (genvar gi = 0; gi < 2; gi++) begin : g_mag
    assign mag[gi] = (samp[gi] == 26'h2000000) ? 25'h1FFFFFF :
                     samp[gi][25] ? (~samp[gi][24:0] + 25'd1) : samp[gi][24:0];
  end

  logic [ACC_W-1:0] sum_i, sum_q;
  logic             win_end, good_win;
  assign sum_i   = acc_i_reg + ACC_W'(mag[0]);
  assign sum_q   = acc_q_reg + ACC_W'(mag[1]);
  assign win_end = ((state_reg == ST_MEASURE) || (state_reg == ST_TRACK)) && (win_pos_reg == WIN_LAST);
  // Verdict uses the sums including the window's final sample, so it lands on that same edge.
  assign good_win = (CMP_W'(sum_i) >= CMP_W'({sum_q, 1'b0})) && (CMP_W'(sum_i) >= CMP_W'(MIN_E));

  logic signed [4:0] sweep_adv;
  always_comb begin
    sweep_adv = '0;
    if (SWEEP_EN) begin
      if (sweep_reg > 5'sd0)
        sweep_adv = -sweep_reg;
      else if (sweep_reg != POS_MIN)
        sweep_adv = 5'sd1 - sweep_reg;
    end
  end

  always_comb begin
    state_next   = state_reg;
    settle_next  = settle_reg;
    win_pos_next = win_pos_reg;
    acc_i_next   = acc_i_reg;
    acc_q_next   = acc_q_reg;
    good_next    = good_reg;
    bad_next     = bad_reg;
    dwell_next   = dwell_reg;
    lock_next    = lock_reg;
    sweep_next   = sweep_reg;
    case (state_reg)
      ST_CLEAR: begin
        state_next   = ST_SETTLE;
        settle_next  = '0;
        win_pos_next = '0;
        acc_i_next   = '0;
        acc_q_next   = '0;
        good_next    = '0;
        bad_next     = '0;
        dwell_next   = '0;
      end
      ST_SETTLE: begin
        if (settle_reg == SETTLE_LAST) begin
          state_next   = ST_MEASURE;
          win_pos_next = '0;
          acc_i_next   = '0;
          acc_q_next   = '0;
        end else begin
          settle_next = settle_reg + SET_ONE;
        end
      end
      ST_MEASURE, ST_TRACK: begin
        win_pos_next = win_pos_reg + WIN_ONE;
        if (!win_end) begin
          acc_i_next = sum_i;
          acc_q_next = sum_q;
        end else begin
          acc_i_next = '0;
          acc_q_next = '0;
          if (state_reg == ST_MEASURE) begin
            if (good_win) begin
              if (good_reg == LOCK_LAST) begin
                state_next = ST_TRACK;
                lock_next  = 1'b1;
                bad_next   = '0;
              end else begin
                good_next = good_reg + CNT_ONE;
              end
            end else begin
              good_next = '0;
              if (dwell_reg == DWELL_LAST) begin
                state_next = ST_CLEAR;
                sweep_next = sweep_adv;
              end else begin
                dwell_next = dwell_reg + CNT_ONE;
              end
            end
          end else if (good_win) begin
            bad_next = '0;
          end else if (bad_reg == UNLOCK_LAST) begin
            state_next = ST_CLEAR;
            lock_next  = 1'b0;
            sweep_next = '0;
          end else begin
            bad_next = bad_reg + CNT_ONE;
          end
        end
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  // Carrier follows sweep_next so the new frequency lands on the edge that enters CLEAR.
  logic [29:0] pos_ext, offset;
  assign pos_ext      = {{25{sweep_next[4]}}, sweep_next};
  assign offset       = pos_ext * STEP;
  assign carrier_next = CENTER + offset;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= ST_CLEAR;
      settle_reg  <= '0;
      win_pos_reg <= '0;
      acc_i_reg   <= '0;
      acc_q_reg   <= '0;
      good_reg    <= '0;
      bad_reg     <= '0;
      dwell_reg   <= '0;
      lock_reg    <= 1'b0;
      sweep_reg   <= '0;
      carrier_reg <= CENTER;
    end else begin
      state_reg   <= state_next;
      settle_reg  <= settle_next;
      win_pos_reg <= win_pos_next;
      acc_i_reg   <= acc_i_next;
      acc_q_reg   <= acc_q_next;
      good_reg    <= good_next;
      bad_reg     <= bad_next;
      dwell_reg   <= dwell_next;
      lock_reg    <= lock_next;
      sweep_reg   <= sweep_next;
      carrier_reg <= carrier_next;
    end
  end

  assign bus.carrier   = carrier_reg;
  assign bus.loop_clr  = (state_reg == ST_CLEAR);
  assign bus.lock      = lock_reg;
  assign bus.acq_state = state_reg;
  assign bus.sweep_pos = sweep_reg;

endmodule

// File: tb/tb_costas_acq_ctrl.sv
// Self-checking bench for costas_acq_ctrl: directed timing cases plus randomized segments vs a window-level model.
module tb_costas_acq_ctrl;

  localparam logic [29:0] CENTER     = 30'd53687091;
  localparam logic [29:0] STEP       = 30'd268435;
  localparam int          NSTEP      = 8;
  localparam int          WIN_LOG2   = 4;
  localparam int          WIN        = 1 << WIN_LOG2;
  localparam int          SETTLE_CYC = 20;
  localparam int          DWELL_WIN  = 4;
  localparam int          LOCK_CNT   = 3;
  localparam int          UNLOCK_CNT = 8;
  localparam logic [31:0] MIN_E      = 32'd1 << 24;
  localparam int          NORD       = 2 * NSTEP + 1;
  localparam int          DWELL_PER  = 1 + SETTLE_CYC + DWELL_WIN * WIN;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  costas_acq_ctrl_if bus ();

  costas_acq_ctrl #(
    .CENTER(CENTER), .STEP(STEP), .NSTEP(NSTEP), .WIN_LOG2(WIN_LOG2),
    .SETTLE_CYC(SETTLE_CYC), .DWELL_WIN(DWELL_WIN), .LOCK_CNT(LOCK_CNT),
    .UNLOCK_CNT(UNLOCK_CNT), .MIN_E(MIN_E)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  endtask

  task automatic check_val(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phases and windows tracked as plain counts and sums.
  int     order [NORD];
  int     m_phase, m_timer, m_nsamp, m_good, m_bad, m_dwell, m_idx;
  bit     m_lock;
  longint m_si, m_sq;

  function automatic longint mag_of(input int v);
    if (v == -(1 << 25)) return longint'((1 << 25) - 1);
    return (v < 0) ? longint'(-v) : longint'(v);
  endfunction

  function automatic longint exp_carrier();
    longint c;
    c = longint'(CENTER) + longint'(order[m_idx]) * longint'(STEP);
    c = ((c % (64'sd1 << 30)) + (64'sd1 << 30)) % (64'sd1 << 30);
    return c;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_timer = 0; m_nsamp = 0; m_good = 0; m_bad = 0; m_dwell = 0;
    m_idx = 0; m_lock = 1'b0; m_si = 0; m_sq = 0;
  endtask

  task automatic model_step(input int di_v, input int dq_v, input bit rstn);
    bit good;
    if (!rstn) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: begin
        m_phase = 1; m_timer = 0; m_good = 0; m_bad = 0; m_dwell = 0;
      end
      1: begin
        m_timer++;
        if (m_timer == SETTLE_CYC) begin
          m_phase = 2; m_si = 0; m_sq = 0; m_nsamp = 0;
        end
      end
      default: begin
        m_si += mag_of(di_v);
        m_sq += mag_of(dq_v);
        m_nsamp++;
        if (m_nsamp == WIN) begin
          good = (m_si >= 2 * m_sq) && (m_si >= longint'(MIN_E));
          m_si = 0; m_sq = 0; m_nsamp = 0;
          if (m_phase == 2) begin
            if (good) begin
              m_good++;
              if (m_good == LOCK_CNT) begin
                m_phase = 3; m_lock = 1'b1; m_bad = 0;
              end
            end else begin
              m_good = 0;
              m_dwell++;
              if (m_dwell == DWELL_WIN) begin
`ifdef ACQ_SWEEP_EN
                m_idx = (m_idx + 1) % NORD;
`endif
                m_phase = 0;
              end
            end
          end else if (good) begin
            m_bad = 0;
          end else begin
            m_bad++;
            if (m_bad == UNLOCK_CNT) begin
              m_lock = 1'b0; m_idx = 0; m_phase = 0;
            end
          end
        end
      end
    endcase
  endtask

  // Drive one sample, advance the model, then compare after the active edge.
  task automatic cycle_step(input int di_v, input int dq_v, input bit rstn);
    bus.di  = 26'(di_v);
    bus.dq  = 26'(dq_v);
    reset_n = rstn;
    model_step(di_v, dq_v, rstn);
    @(negedge clk);
    check_val("acq_state", 64'(bus.acq_state), 64'(m_phase));
    check_val("lock", 64'(bus.lock), 64'(m_lock));
    check_val("loop_clr", 64'(bus.loop_clr), 64'(m_phase == 0));
    check_val("sweep_pos", $signed(bus.sweep_pos), 64'(order[m_idx]));
    check_val("carrier", 64'(bus.carrier), exp_carrier());
    if (tests_failed >= 40) finish_run();
  endtask

  task automatic gen_sample(input int mode, input int d, output int di_v, output int dq_v);
    int a;
    bit si, sq;
    si = 1'($urandom_range(0, 1));
    sq = 1'($urandom_range(0, 1));
    case (mode)
      0: begin a = int'($urandom_range(1 << 22, (1 << 25) - 1)); di_v = si ? -a : a;
               dq_v = int'($urandom_range(0, a / 4)); dq_v = sq ? -dq_v : dq_v; end
      1: begin a = int'($urandom_range(1, (1 << 25) - 1)); di_v = si ? -a : a; dq_v = sq ? -a : a; end
      2: begin a = (1 << 20) - 1; di_v = si ? -a : a; dq_v = 0; end
      3: begin di_v = si ? -2 * d : 2 * d; dq_v = sq ? -d : d; end
      4: begin di_v = si ? -(2 * d - 1) : 2 * d - 1; dq_v = sq ? -d : d; end
      5: begin di_v = -(1 << 25); a = int'($urandom_range(0, 1 << 20)); dq_v = sq ? -a : a; end
      6: begin a = int'($urandom); di_v = a >>> 6; a = int'($urandom); dq_v = a >>> 6; end
      default: begin di_v = si ? -(1 << 20) : (1 << 20); dq_v = 0; end
    endcase
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle_step(0, 0, 1'b0);
  endtask

  // From the last reset cycle, run a constant input and report the cycle lock first appears.
  task automatic lock_rise(input int di_v, input int dq_v, output int rise);
    int cyc;
    cyc  = 1;
    rise = 0;
    for (int i = 0; i < 200 && rise == 0; i++) begin
      cycle_step(di_v, dq_v, 1'b1);
      cyc++;
      if (bus.lock === 1'b1) rise = cyc;
    end
  endtask

  initial begin
    int rise, di_v, dq_v, pulses, last_clr, exp_pos, mode, len, d;
    order[0] = 0;
    for (int k = 1; k <= NSTEP; k++) begin
      order[2 * k - 1] = k;
      order[2 * k]     = -k;
    end
    model_reset();
    bus.di = '0;
    bus.dq = '0;

    // Minimum lock time with window energy exactly at MIN_E.
    do_reset(3);
    lock_rise(1 << 20, 0, rise);
    check_val("lock_rise_cyc", 64'(rise), 64'(1 + SETTLE_CYC + LOCK_CNT * WIN + 1));
    $display("[TB] directed lock at cycle %0d carrier=%0d", rise, bus.carrier);

    // 7 bad windows then a good one keeps lock; 8 bad windows drop it.
    for (int i = 0; i < 7 * WIN; i++) begin gen_sample(1, 0, di_v, dq_v); cycle_step(di_v, dq_v, 1'b1); end
    for (int i = 0; i < WIN; i++) cycle_step(1 << 20, 0, 1'b1);
    check_val("lock_hold_7bad", 64'(bus.lock), 64'd1);
    for (int i = 0; i < 8 * WIN; i++) begin gen_sample(1, 0, di_v, dq_v); cycle_step(di_v, dq_v, 1'b1); end
    check_val("unlock_lock", 64'(bus.lock), 64'd0);
    check_val("unlock_clr", 64'(bus.loop_clr), 64'd1);
    check_val("unlock_sweep", $signed(bus.sweep_pos), 64'sd0);
    check_val("unlock_carrier", 64'(bus.carrier), 64'(CENTER));
    $display("[TB] directed unlock lock=%0d sweep=%0d", bus.lock, bus.sweep_pos);

    // Saturating magnitude still locks at the minimum time.
    do_reset(2);
    lock_rise(-(1 << 25), 0, rise);
    check_val("sat_lock_cyc", 64'(rise), 64'(1 + SETTLE_CYC + LOCK_CNT * WIN + 1));
    $display("[TB] directed saturation lock at cycle %0d", rise);

    // Ratio failure on every window: full sweep cycle, one clear pulse per dwell period.
    do_reset(2);
    pulses = 0;
    last_clr = 1;
    for (int c = 2; c < 2 + NORD * DWELL_PER; c++) begin
      cycle_step(1 << 20, 1 << 20, 1'b1);
      if (bus.loop_clr === 1'b1) begin
        pulses++;
        check_val("clr_period", 64'(c - last_clr), 64'(DWELL_PER));
        last_clr = c;
`ifdef ACQ_SWEEP_EN
        exp_pos = (pulses % NORD == 0) ? 0 : ((pulses % NORD) % 2 == 1 ? (pulses % NORD + 1) / 2 : -((pulses % NORD) / 2));
`else
        exp_pos = 0;
`endif
        check_val("sweep_seq", $signed(bus.sweep_pos), 64'(exp_pos));
      end
    end
    check_val("clr_pulses", 64'(pulses), 64'(NORD));
    $display("[TB] directed sweep pulses=%0d final sweep=%0d", pulses, bus.sweep_pos);

    // Randomized segments, some opening with a one-cycle reset anywhere in the flow.
    for (int seg = 0; seg < 80; seg++) begin
      mode = int'($urandom_range(0, 9));
      if (mode > 7) mode = 0;
      len  = int'($urandom_range(20, 300));
      d    = int'($urandom_range(1 << 20, 1 << 23));
      if ($urandom_range(0, 99) < 15) cycle_step(0, 0, 1'b0);
      for (int i = 0; i < len; i++) begin
        gen_sample(mode, d, di_v, dq_v);
        cycle_step(di_v, dq_v, 1'b1);
      end
      $display("[TB] seg %0d mode %0d len %0d state=%0d lock=%0d sweep=%0d", seg, mode, len,
               bus.acq_state, bus.lock, bus.sweep_pos);
    end

    finish_run();
  end

endmodule
